pack_serializer: RTL

- Downstream read stage of the ping-pong packet buffer `memory_pack`.
- Waits until a full packet is available, then drives the buffer's read address port and emits a serial bit stream: preamble first, then the SIZE_BIT_PACK payload bits.
- Output uses a valid/ready handshake.
- Pulses a done strobe when a packet has been consumed, so the buffer can swap banks.

---
 rtl/pack_serializer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/pack_serializer.sv
`default_nettype none
// ============================================================================
// Module      : pack_serializer
// Description : Read stage of the memory_pack ping-pong buffer. Once a whole
//               packet is available it walks the buffer read address and
//               emits a valid/ready serial stream (optional preamble, then
//               SIZE_BIT_PACK payload bits), then pulses o_pack_done.
//               Build option PACK_SERIALIZER_PREAMBLE_EN: when defined, a
//               SIZE_PREAMBLE-bit PREAMBLE pattern (MSB first) leads every
//               packet; when undefined a single PRIME cycle replaces it.
// Revision    : 1.0 - initial release
// ============================================================================
module pack_serializer #(
  parameter int                       SIZE_BIT_PACK    = 1976,
  parameter int                       SIZE_PREAMBLE    = 32,
  parameter logic [SIZE_PREAMBLE-1:0] PREAMBLE         = 32'h1ACF_FC1D,
  parameter int                       SIZE_ADDR_OUTPUT = $clog2(SIZE_BIT_PACK)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_pack_ready,
  output logic                      o_pack_done,
  output logic [SIZE_ADDR_OUTPUT:0] o_addr_pack_out,
  input  logic                      i_mem_data,
  output logic                      o_data,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic                      o_busy
);

  localparam int            AW         = SIZE_ADDR_OUTPUT + 1;
  localparam logic [AW-1:0] C_BIT_LAST = AW'(SIZE_BIT_PACK - 1);
  // A packet is only started when the preamble configuration is coherent.
  localparam bit            C_CFG_OK   = (SIZE_PREAMBLE >= 1) &&
                                         ($bits(PREAMBLE) == SIZE_PREAMBLE);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREAMBLE = 3'd1,
    S_PRIME    = 3'd2,
    S_PAYLOAD  = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t        state_q;
  logic [AW-1:0] bit_idx_q;
  logic          valid_q;
  logic          done_q;
  logic          busy_q;
  logic          data_last_q;
  logic          w_xfer;

`ifdef PACK_SERIALIZER_PREAMBLE_EN
  localparam int             PCW        = $clog2(SIZE_PREAMBLE + 1);
  localparam logic [PCW-1:0] C_PRE_LAST = PCW'(SIZE_PREAMBLE - 1);

  logic [SIZE_PREAMBLE-1:0] pre_sr_q;
  logic [PCW-1:0]           pre_cnt_q;
`endif

  assign w_xfer      = valid_q & i_ready;
  assign o_valid     = valid_q;
  assign o_pack_done = done_q;
  assign o_busy      = busy_q;

  // Look one bit ahead on a payload transfer so the 1-cycle BRAM read lands
  // exactly when the next bit is needed; otherwise keep re-reading bit_idx.
  always_comb begin
    o_addr_pack_out = bit_idx_q;
    if ((state_q == S_PAYLOAD) && w_xfer) begin
      o_addr_pack_out = bit_idx_q + AW'(1);
    end
  end

  // Serial bit source: preamble MSB, live memory bit, or the last bit sent.
  always_comb begin
    o_data = data_last_q;
`ifdef PACK_SERIALIZER_PREAMBLE_EN
    if (state_q == S_PREAMBLE) begin
      o_data = pre_sr_q[SIZE_PREAMBLE-1];
    end
`endif
    if (state_q == S_PAYLOAD) begin
      o_data = i_mem_data;
    end
  end

  // Packet sequencing FSM with registered valid/done/busy outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      bit_idx_q   <= '0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      data_last_q <= 1'b0;
`ifdef PACK_SERIALIZER_PREAMBLE_EN
      pre_sr_q    <= '0;
      pre_cnt_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (valid_q) begin
        data_last_q <= o_data;
      end
      case (state_q)
        S_IDLE: begin
          if (i_pack_ready && C_CFG_OK) begin
            bit_idx_q <= '0;
            busy_q    <= 1'b1;
`ifdef PACK_SERIALIZER_PREAMBLE_EN
            pre_sr_q  <= PREAMBLE;
            pre_cnt_q <= '0;
            valid_q   <= 1'b1;
            state_q   <= S_PREAMBLE;
`else
            state_q   <= S_PRIME;
`endif
          end
        end
`ifdef PACK_SERIALIZER_PREAMBLE_EN
        S_PREAMBLE: begin
          if (w_xfer) begin
            pre_sr_q  <= pre_sr_q << 1;
            pre_cnt_q <= pre_cnt_q + PCW'(1);
            if (pre_cnt_q == C_PRE_LAST) begin
              state_q <= S_PAYLOAD;
            end
          end
        end
`endif
        S_PRIME: begin
          valid_q <= 1'b1;
          state_q <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (w_xfer) begin
            if (bit_idx_q == C_BIT_LAST) begin
              bit_idx_q <= '0;
              valid_q   <= 1'b0;
              done_q    <= 1'b1;
              state_q   <= S_DONE;
            end else begin
              bit_idx_q <= bit_idx_q + AW'(1);
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
